wb_to_cernbe_bridge: RTL and testbench
======================================

Name: wb_to_cernbe_bridge

Overview:
- Upstream master stage for the generated CERN-BE register banks (Addr/RdMem/WrMem/RdDone/WrDone/RdData/WrData bus).
- Accepts single Wishbone pipelined-slave transactions from the system interconnect.
- Converts each one into a one-cycle RdMem or WrMem strobe, waits for the matching Done, and returns wb ack (or err on timeout or illegal access).
- One outstanding transaction at a time; backpressure via wb_stall_o.

Parameters:
- ADDR_WIDTH, 16: byte-address width. The bank receives word address bits [ADDR_WIDTH-1:2].
- TIMEOUT, 255: wait cycles without Done before the bridge errors. Legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  1=write
- wb_adr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- wb_sel_i  in  4  byte selects
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid with wb_ack_o
- wb_ack_o  out  1  one-cycle ack
- wb_err_o  out  1  one-cycle error
- wb_stall_o  out  1  high = request not accepted
- be_addr_o  out  ADDR_WIDTH-2  word address to bank
- be_wr_data_o  out  32  write data to bank
- be_rd_mem_o  out  1  read strobe, one cycle
- be_wr_mem_o  out  1  write strobe, one cycle
- be_rd_data_i  in  32  bank read data, valid with be_rd_done_i
- be_rd_done_i  in  1  read complete
- be_wr_done_i  in  1  write complete

Behaviour:
- Reset: rst_n, synchronous, active-low. All outputs are registered and clear to 0, except wb_stall_o, which is 1 during reset. State returns to IDLE.
- Reset mid-transaction aborts the transaction silently: no ack, no err.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- Request accepted = wb_cyc_i & wb_stb_i & ~wb_stall_o. wb_stall_o = 0 only in IDLE.
- IDLE, request accepted:
  - Latch adr[ADDR_WIDTH-1:2] into be_addr_o and dat into be_wr_data_o.
  - Write with wb_sel_i != 4'hF: go to RESP with err=1. No strobe is issued, because banks have no byte enables.
  - Otherwise go to ISSUE.
- ISSUE: be_rd_mem_o = ~we or be_wr_mem_o = we, high for exactly this one cycle. Clear timeout counter to 0. Go to WAIT.
- WAIT:
  - be_addr_o and be_wr_data_o held stable until leaving WAIT. The bank decodes the read address combinationally.
  - Sample only the Done matching the direction. The other Done and any Done in IDLE/ISSUE/RESP are ignored.
  - Done=1: capture be_rd_data_i for reads, go to RESP with ack.
  - Else if counter == TIMEOUT: go to RESP with err.
  - Else counter += 1, saturating, width $clog2(TIMEOUT+1).
  - Done and timeout in the same cycle: Done wins.
- RESP: exactly one of wb_ack_o or wb_err_o pulses for one cycle. wb_dat_o holds captured data on read ack, 0 otherwise. Next state IDLE.
- Abort: wb_cyc_i low in ISSUE or WAIT goes to DRAIN.
- DRAIN: keep waiting for Done or timeout, then go to IDLE with no ack/err. A new request cannot be accepted before the bank finishes.
- wb_cyc_i low in RESP: the pulse is still driven; the master ignores it.
- Read latency with a bank whose Done comes 1 cycle after the strobe:
  - T0 accept; T1 ISSUE; T2 Done; T3 ack. Next request can be accepted at T4.
- Write latency with a 2-cycle Done: ack at T4.
- Timeout err appears TIMEOUT+3 cycles after accept.
- wb_dat_o is 0 whenever wb_ack_o is low.

Decomposition:
- Package cernbe_bridge_pkg: state enum (IDLE, ISSUE, WAIT, RESP, DRAIN), constant SEL_FULL = 4'hF, function for the timeout counter width.
- Sub-module cernbe_timeout_cnt: clear/enable/saturating counter with an expired flag, parameterised by TIMEOUT.

Test Plan:
- Write: adr 0x0004, dat 0xDEADBEEF, sel F; bank asserts WrDone 2 cycles after the strobe -> be_addr_o=1 and be_wr_mem_o for 1 cycle; wb_ack_o 1 cycle after WrDone; err stays 0.
- Read: adr 0x0000, bank returns 0x12345678 with RdDone 1 cycle after the strobe -> wb_dat_o=0x12345678 with wb_ack_o at T3; wb_stall_o high T1..T3.
- Partial write: sel 4'b0011 -> no be_wr_mem_o; wb_err_o at T1.
- Timeout, TIMEOUT=4, Done never asserted -> wb_err_o exactly 7 cycles after accept, then back in IDLE; next read completes normally.
- Abort: cyc dropped 1 cycle after accept, RdDone 3 cycles later -> no ack/err; stall stays high until Done, then 0.
- Simultaneous: RdDone in the cycle counter==TIMEOUT -> ack, not err. A spurious WrDone during a read WAIT is ignored.
- Reset pulse during WAIT -> all outputs 0 next cycle, stall 1 during reset; a new transaction after reset completes normally.

Source files
------------

// File: rtl/cernbe_bridge_pkg.sv
// Shared definitions for the Wishbone to CERN-BE register bank bridge.
// Contents:
//   state_t   - bridge FSM states
//   SEL_FULL  - byte-select pattern required for a write (banks have no byte enables)
//   cnt_width - width of a counter able to hold the value TIMEOUT
package cernbe_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    localparam logic [3:0] SEL_FULL = 4'hF;

    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cernbe_timeout_cnt.sv
// Wait-cycle counter for the bridge.
// It is cleared synchronously and counts up while enabled, then holds at TIMEOUT.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   clr        - force the count to zero (takes priority over en)
//   en         - count one more wait cycle
//   expired    - the count has reached TIMEOUT
module cernbe_timeout_cnt
    import cernbe_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/wb_to_cernbe_bridge.sv
// Bridge from a Wishbone pipelined slave port to the CERN-BE register bank bus.
// The bridge handles one transaction at a time.
// Each accepted access becomes a single RdMem or WrMem strobe.
// The bridge then waits for the matching Done and answers with one wb_ack_o or wb_err_o pulse.
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   wb_cyc_i, wb_stb_i  - Wishbone cycle and strobe
//   wb_we_i             - 1 = write
//   wb_adr_i            - byte address; bits [1:0] are ignored
//   wb_sel_i            - byte selects; a write needs all four
//   wb_dat_i / wb_dat_o - write data in / read data out (wb_dat_o is nonzero only with ack)
//   wb_ack_o, wb_err_o  - one-cycle response pulses
//   wb_stall_o          - high while a request cannot be accepted
//   be_addr_o           - word address to the bank
//   be_wr_data_o        - write data to the bank
//   be_rd_mem_o, be_wr_mem_o   - one-cycle read and write strobes
//   be_rd_data_i        - bank read data, valid with be_rd_done_i
//   be_rd_done_i, be_wr_done_i - bank completion flags
module wb_to_cernbe_bridge
    import cernbe_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o,
    output logic [ADDR_WIDTH-3:0] be_addr_o,
    output logic [31:0]           be_wr_data_o,
    output logic                  be_rd_mem_o,
    output logic                  be_wr_mem_o,
    input  logic [31:0]           be_rd_data_i,
    input  logic                  be_rd_done_i,
    input  logic                  be_wr_done_i
);

    state_t state;
    logic   we_q;
    logic   accept;
    logic   done;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_expired;
    logic   unused_adr_lsb;

    // The bank is word addressed, so the byte lane bits carry no information.
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    assign accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;

    // Only the Done that matches the direction of the current access counts.
    assign done = we_q ? be_wr_done_i : be_rd_done_i;

    // The count starts at zero in the first WAIT/DRAIN cycle.
    // It stops once Done arrives or the limit is reached.
    assign cnt_clr = (state == ISSUE);
    assign cnt_en  = ((state == WAIT) || (state == DRAIN)) && !done && !cnt_expired;

    cernbe_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            wb_stall_o   <= 1'b1;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            be_rd_mem_o  <= 1'b0;
            be_wr_mem_o  <= 1'b0;
            be_addr_o    <= '0;
            be_wr_data_o <= '0;
        end else begin
            // Pulse outputs default low; wb_dat_o is only nonzero alongside ack.
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            be_rd_mem_o <= 1'b0;
            be_wr_mem_o <= 1'b0;

            case (state)
                IDLE: begin
                    wb_stall_o <= 1'b0;
                    if (accept) begin
                        be_addr_o    <= wb_adr_i[ADDR_WIDTH-1:2];
                        be_wr_data_o <= wb_dat_i;
                        we_q         <= wb_we_i;
                        wb_stall_o   <= 1'b1;
                        // A partial write cannot be expressed on the bank bus.
                        // Reject it without touching the bank.
                        if (wb_we_i && (wb_sel_i != SEL_FULL)) begin
                            wb_err_o <= 1'b1;
                            state    <= RESP;
                        end else begin
                            be_rd_mem_o <= ~wb_we_i;
                            be_wr_mem_o <= wb_we_i;
                            state       <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    state <= wb_cyc_i ? WAIT : DRAIN;
                end

                WAIT: begin
                    if (!wb_cyc_i) begin
                        // The master has gone away.
                        // If the bank is already finishing, return to IDLE at once.
                        if (done || cnt_expired) begin
                            wb_stall_o <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (done) begin
                        wb_ack_o <= 1'b1;
                        if (!we_q) begin
                            wb_dat_o <= be_rd_data_i;
                        end
                        state <= RESP;
                    end else if (cnt_expired) begin
                        wb_err_o <= 1'b1;
                        state    <= RESP;
                    end
                end

                RESP: begin
                    wb_stall_o <= 1'b0;
                    state      <= IDLE;
                end

                DRAIN: begin
                    // Let the bank finish the aborted access before taking new work.
                    if (done || cnt_expired) begin
                        wb_stall_o <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_to_cernbe_bridge.sv
// Self-checking bench for wb_to_cernbe_bridge (ADDR_WIDTH=16, TIMEOUT=4).
// It applies a table of directed transactions, then randomized transactions checked
// against a latency/response model.
// It ends with hand-written abort and mid-transaction reset sequences.
module tb_wb_to_cernbe_bridge;

    localparam int AW = 16;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [15:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_stall_o;
    logic [13:0] be_addr_o;
    logic [31:0] be_wr_data_o, be_rd_data_i;
    logic        be_rd_mem_o, be_wr_mem_o, be_rd_done_i, be_wr_done_i;

    always #5 clk = ~clk;

    wb_to_cernbe_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_we_i      (wb_we_i),
        .wb_adr_i     (wb_adr_i),
        .wb_sel_i     (wb_sel_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .wb_stall_o   (wb_stall_o),
        .be_addr_o    (be_addr_o),
        .be_wr_data_o (be_wr_data_o),
        .be_rd_mem_o  (be_rd_mem_o),
        .be_wr_mem_o  (be_wr_mem_o),
        .be_rd_data_i (be_rd_data_i),
        .be_rd_done_i (be_rd_done_i),
        .be_wr_done_i (be_wr_done_i)
    );

    // kind: 1 = ack, 2 = err (0 = no response, 3 = both)
    // dly: cycles from strobe to matching Done; 99 = never
    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          dly;
        logic [31:0] rdat;
        logic        spur;
        int          exp_kind;
        int          exp_lat;
        logic [31:0] exp_dat;
        int          exp_str;
    } vec_t;

    vec_t vecs[12];

    int n_cmp = 0;
    int n_bad = 0;

    // results of the last run_txn
    int          r_kind, r_lat, r_rd, r_wr;
    logic [31:0] r_dat, r_wd;
    logic        r_hold, r_stall, r_leak, r_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected behaviour derived from the bridge rules.
    // The strobe is in cycle 1 after accept.
    // A Done d cycles later is honoured if it falls within the WAIT window.
    // The WAIT window is cycles 2..TO+2.
    task automatic model(input logic we, input logic [3:0] sel, input int dly,
                         output int kind, output int lat, output int str);
        if (we && sel != 4'hF) begin
            kind = 2; lat = 1; str = 0;
        end else if (dly >= 1 && dly <= TO + 1) begin
            kind = 1; lat = dly + 2; str = 1;
        end else begin
            kind = 2; lat = TO + 3; str = 1;
        end
    endtask

    // Runs one transaction with a bank model that answers dly cycles after the strobe.
    // It starts and ends on a negedge.
    task automatic run_txn(input vec_t v);
        int          st;
        int          w;
        logic [13:0] ea;
        ea = v.adr[15:2];
        r_kind = 0; r_lat = 0; r_rd = 0; r_wr = 0; r_dat = '0; r_wd = '0;
        r_hold = 1'b1; r_stall = 1'b1; r_leak = 1'b0; r_idle = 1'b1;
        w = 0;
        while (wb_stall_o !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
        wb_adr_i = v.adr; wb_sel_i = v.sel; wb_dat_i = v.wdat;
        @(negedge clk);
        wb_stb_i = 1'b0;
        wb_adr_i = 16'($urandom); wb_dat_i = $urandom; wb_sel_i = 4'($urandom);
        st = -1;
        for (int t = 1; t <= 40; t++) begin
            if (wb_stall_o !== 1'b1) r_stall = 1'b0;
            if (be_addr_o !== ea) r_hold = 1'b0;
            if (be_rd_mem_o === 1'b1) begin r_rd++; st = t; end
            if (be_wr_mem_o === 1'b1) begin r_wr++; st = t; end
            if (wb_ack_o !== 1'b1 && wb_dat_o !== 32'h0) r_leak = 1'b1;
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
                r_kind = (wb_ack_o === 1'b1 && wb_err_o === 1'b1) ? 3 : (wb_ack_o === 1'b1 ? 1 : 2);
                r_lat = t;
                r_dat = wb_dat_o;
                r_wd  = be_wr_data_o;
                break;
            end
            be_rd_done_i = 1'b0; be_wr_done_i = 1'b0; be_rd_data_i = $urandom;
            if (st > 0 && t == st + v.dly) begin
                if (v.we) be_wr_done_i = 1'b1;
                else begin be_rd_done_i = 1'b1; be_rd_data_i = v.rdat; end
            end
            if (v.spur && st > 0 && t == st + 1) begin
                if (v.we) be_rd_done_i = 1'b1;
                else be_wr_done_i = 1'b1;
            end
            @(negedge clk);
        end
        be_rd_done_i = 1'b0; be_wr_done_i = 1'b0; wb_cyc_i = 1'b0;
        @(negedge clk);
        r_idle = wb_stall_o;
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        chk({tag, " kind"},     32'(r_kind), 32'(v.exp_kind));
        chk({tag, " latency"},  32'(r_lat),  32'(v.exp_lat));
        chk({tag, " rd_data"},  r_dat,       v.exp_dat);
        chk({tag, " rd_strobes"}, 32'(r_rd), v.we ? 32'd0 : 32'(v.exp_str));
        chk({tag, " wr_strobes"}, 32'(r_wr), v.we ? 32'(v.exp_str) : 32'd0);
        chk({tag, " addr_held"}, {31'd0, r_hold}, 32'd1);
        chk({tag, " stall_busy"}, {31'd0, r_stall}, 32'd1);
        chk({tag, " dat_leak"}, {31'd0, r_leak}, 32'd0);
        chk({tag, " wr_data"},  r_wd,        v.wdat);
        chk({tag, " idle_stall"}, {31'd0, r_idle}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " stall"},   {31'd0, wb_stall_o}, 32'd1);
        chk({tag, " ack"},     {31'd0, wb_ack_o},   32'd0);
        chk({tag, " err"},     {31'd0, wb_err_o},   32'd0);
        chk({tag, " dat"},     wb_dat_o,            32'd0);
        chk({tag, " rd_mem"},  {31'd0, be_rd_mem_o}, 32'd0);
        chk({tag, " wr_mem"},  {31'd0, be_wr_mem_o}, 32'd0);
        chk({tag, " addr"},    {18'd0, be_addr_o},  32'd0);
        chk({tag, " wr_data"}, be_wr_data_o,        32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k, l, s;
        logic pulse;

        //            we    adr       sel   wdat          dly rdat          spur kind lat exp_dat       str
        vecs[0]  = '{1'b1, 16'h0004, 4'hF, 32'hDEADBEEF, 2,  32'h0,        1'b0, 1, 4, 32'h0,        1};
        vecs[1]  = '{1'b0, 16'h0000, 4'hF, 32'h0,        1,  32'h12345678, 1'b0, 1, 3, 32'h12345678, 1};
        vecs[2]  = '{1'b1, 16'h0008, 4'h3, 32'hCAFEF00D, 1,  32'h0,        1'b0, 2, 1, 32'h0,        0};
        vecs[3]  = '{1'b0, 16'h000C, 4'hF, 32'h0,        99, 32'hAAAA5555, 1'b0, 2, 7, 32'h0,        1};
        vecs[4]  = '{1'b0, 16'h0010, 4'hF, 32'h0,        1,  32'h0BADC0DE, 1'b0, 1, 3, 32'h0BADC0DE, 1};
        vecs[5]  = '{1'b0, 16'h0014, 4'hF, 32'h0,        5,  32'h55AA55AA, 1'b0, 1, 7, 32'h55AA55AA, 1};
        vecs[6]  = '{1'b0, 16'h0018, 4'hF, 32'h0,        6,  32'h00000001, 1'b0, 2, 7, 32'h0,        1};
        vecs[7]  = '{1'b0, 16'h001C, 4'hF, 32'h0,        3,  32'h89ABCDEF, 1'b1, 1, 5, 32'h89ABCDEF, 1};
        vecs[8]  = '{1'b1, 16'h0020, 4'hF, 32'h01234567, 1,  32'h0,        1'b1, 1, 3, 32'h0,        1};
        vecs[9]  = '{1'b1, 16'h0024, 4'h0, 32'hFFFFFFFF, 1,  32'h0,        1'b0, 2, 1, 32'h0,        0};
        vecs[10] = '{1'b0, 16'h0028, 4'hF, 32'h0,        0,  32'h77777777, 1'b0, 2, 7, 32'h0,        1};
        vecs[11] = '{1'b0, 16'hFFFF, 4'hF, 32'h0,        4,  32'hFEDCBA98, 1'b0, 1, 6, 32'hFEDCBA98, 1};

        rst_n = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
        be_rd_data_i = '0; be_rd_done_i = 1'b0; be_wr_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        foreach (vecs[i]) begin
            run_txn(vecs[i]);
            check_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            v.we   = 1'($urandom);
            v.adr  = 16'($urandom);
            v.sel  = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
            v.wdat = $urandom;
            v.dly  = ($urandom % 6 == 0) ? 99 : int'($urandom_range(0, 7));
            v.rdat = $urandom;
            v.spur = 1'($urandom);
            model(v.we, v.sel, v.dly, k, l, s);
            v.exp_kind = k;
            v.exp_lat  = l;
            v.exp_str  = s;
            v.exp_dat  = (k == 1 && !v.we) ? v.rdat : 32'h0;
            run_txn(v);
            check_txn($sformatf("rnd%0d", n), v);
        end

        // abort: cyc dropped in ISSUE, RdDone three cycles later
        while (wb_stall_o !== 1'b0) @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0040; wb_sel_i = 4'hF;
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        pulse = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) pulse = 1'b1;
            if (t >= 2 && t <= 6)
                chk($sformatf("abort stall t%0d", t), {31'd0, wb_stall_o}, (t <= 4) ? 32'd1 : 32'd0);
            be_rd_done_i = (t == 4);
            be_rd_data_i = 32'h5A5A5A5A;
            @(negedge clk);
        end
        be_rd_done_i = 1'b0;
        chk("abort no_response", {31'd0, pulse}, 32'd0);

        // reset pulse while waiting for a Done that never comes
        while (wb_stall_o !== 1'b0) @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0050; wb_sel_i = 4'hF;
        wb_dat_i = 32'h13579BDF;
        @(negedge clk);
        wb_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; wb_cyc_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        pulse = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) pulse = 1'b1;
        end
        chk("midreset no_response", {31'd0, pulse}, 32'd0);
        v = '{1'b0, 16'h0060, 4'hF, 32'h0, 1, 32'hA5A5F00F, 1'b0, 1, 3, 32'hA5A5F00F, 1};
        run_txn(v);
        check_txn("after_reset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
